// File: rtl/ball_update_scheduler.sv
// ---------------------------------------------------------------------------
// ball_update_scheduler
// Frame-level sequencer for the bouncing-ball datapath. It counts down a
// startup period and then, on every unpaused frame tick, walks balls
// 0..BALLS-1. Each ball that is due at its own speed divisor is granted the
// shared update/collision datapath through a valid/ready handshake.
//
// Ports
//   clk         system/pixel clock
//   reset       asynchronous, active-high
//   frame_tick  single-cycle pulse, once per frame
//   pause       level, gates the start of new frame scans
//   speed       per-ball speed code, ball i at [2i+1:2i]; moves every code+1 frames
//   upd_ready   shared datapath accepts the current request
//   upd_valid   request to update ball upd_ball
//   upd_ball    index of the ball being updated
//   game_run    startup countdown has finished
//   busy        a frame scan is in progress
//   frame_done  one-cycle pulse after a frame scan completes
//   overrun     sticky, a frame tick arrived while a scan was in progress
// ---------------------------------------------------------------------------
module ball_update_scheduler #(
   parameter int unsigned BALLS          = 4,
   parameter int unsigned STARTUP_FRAMES = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic [2*BALLS-1:0] speed,
   input  logic               upd_ready,
   output logic               upd_valid,
   output logic [1:0]         upd_ball,
   output logic               game_run,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);

   localparam int unsigned IDX_W     = 2;
   localparam int unsigned DIV_W     = 2;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned MAX_BALLS = 4;
   localparam int unsigned SPD_W     = DIV_W * MAX_BALLS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BALLS - 1);

   typedef enum logic [1:0] {
      STARTUP = 2'd0,
      IDLE    = 2'd1,
      SCAN    = 2'd2,
      ISSUE   = 2'd3
   } state_t;

   state_t                            state, state_nxt;
   logic [IDX_W-1:0]                  idx, idx_nxt;
   logic [CNT_W-1:0]                  startup_cnt, startup_cnt_nxt;
   logic [MAX_BALLS-1:0][DIV_W-1:0]   div_cnt, div_cnt_nxt;
   logic                              upd_valid_nxt;
   logic [1:0]                        upd_ball_nxt;
   logic                              game_run_nxt;
   logic                              busy_nxt;
   logic                              frame_done_nxt;
   logic                              overrun_nxt;

   logic [SPD_W-1:0]                  speed_pad;
   logic [DIV_W-1:0]                  cur_div;
   logic [DIV_W-1:0]                  cur_spd;
   logic                              due;
   logic                              is_last;
   logic                              handshake;

   // Zero-pad the speed bus so unused ball slots read as code 0.
   assign speed_pad = SPD_W'(speed);
   assign cur_div   = div_cnt[idx];
   assign cur_spd   = speed_pad[{idx, 1'b0} +: DIV_W];
   assign due       = (cur_div == '0);
   assign is_last   = (idx == LAST_IDX);
   assign handshake = upd_valid && upd_ready;

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= STARTUP;
         idx         <= '0;
         startup_cnt <= CNT_W'(STARTUP_FRAMES);
         div_cnt     <= '0;
         upd_valid   <= 1'b0;
         upd_ball    <= '0;
         game_run    <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         startup_cnt <= startup_cnt_nxt;
         div_cnt     <= div_cnt_nxt;
         upd_valid   <= upd_valid_nxt;
         upd_ball    <= upd_ball_nxt;
         game_run    <= game_run_nxt;
         busy        <= busy_nxt;
         frame_done  <= frame_done_nxt;
         overrun     <= overrun_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt       = state;
      idx_nxt         = idx;
      startup_cnt_nxt = startup_cnt;
      div_cnt_nxt     = div_cnt;
      upd_valid_nxt   = upd_valid;
      upd_ball_nxt    = upd_ball;
      overrun_nxt     = overrun;

      case (state)
         STARTUP: begin
            // Countdown ignores pause; the tick that ends it starts no scan.
            if (frame_tick) begin
               if (startup_cnt <= CNT_W'(1)) begin
                  startup_cnt_nxt = '0;
                  state_nxt       = IDLE;
               end else begin
                  startup_cnt_nxt = startup_cnt - CNT_W'(1);
               end
            end
         end

         IDLE: begin
            if (frame_tick && !pause) begin
               state_nxt = SCAN;
               idx_nxt   = '0;
            end
         end

         SCAN: begin
            if (frame_tick) begin
               overrun_nxt = 1'b1;
            end
            // >= lets a lowered speed code wrap the divisor back to zero.
            div_cnt_nxt[idx] = (cur_div >= cur_spd) ? '0 : cur_div + DIV_W'(1);
            if (due) begin
               state_nxt     = ISSUE;
               upd_valid_nxt = 1'b1;
               upd_ball_nxt  = idx;
            end else if (is_last) begin
               state_nxt = IDLE;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end

         ISSUE: begin
            if (frame_tick) begin
               overrun_nxt = 1'b1;
            end
            if (handshake) begin
               upd_valid_nxt = 1'b0;
               if (is_last) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = SCAN;
                  idx_nxt   = idx + IDX_W'(1);
               end
            end
         end

         default: begin
            state_nxt = STARTUP;
         end
      endcase

      game_run_nxt   = (state_nxt != STARTUP);
      busy_nxt       = (state_nxt == SCAN) || (state_nxt == ISSUE);
      frame_done_nxt = (state_nxt == IDLE) && ((state == SCAN) || (state == ISSUE));
   end

endmodule

// File: tb/tb_ball_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ball_update_scheduler
// Randomised and directed stimulus for ball_update_scheduler, checked against
// a frame-level reference model: per-ball move counters decide which balls
// are due in each frame, and the expected scan length, grant order, startup
// countdown and overrun flag follow from that.
// ---------------------------------------------------------------------------
module tb_ball_update_scheduler;

   localparam int unsigned BALLS   = 4;
   localparam int unsigned STARTUP = 3;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic       pause;
   logic [7:0] speed;
   logic       upd_ready;
   logic       upd_valid;
   logic [1:0] upd_ball;
   logic       game_run;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   ball_update_scheduler #(
      .BALLS          (BALLS),
      .STARTUP_FRAMES (STARTUP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .pause      (pause),
      .speed      (speed),
      .upd_ready  (upd_ready),
      .upd_valid  (upd_valid),
      .upd_ball   (upd_ball),
      .game_run   (game_run),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Reference model state.
   int m_div [BALLS];
   int m_startup;
   bit m_run;
   bit m_active;
   bit m_overrun;
   int elapsed;
   int stalls;
   int grant_cnt [BALLS];
   int exp_q [$];
   int got_q [$];

   int n_checks;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < BALLS; i++) begin
         m_div[i]     = 0;
         grant_cnt[i] = 0;
      end
      m_startup = STARTUP;
      m_run     = 1'b0;
      m_active  = 1'b0;
      m_overrun = 1'b0;
      elapsed   = 0;
      stalls    = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   // A ball moves when its frame counter is zero; the counter then advances
   // modulo (speed+1), restarting at zero if the speed was lowered below it.
   task automatic start_frame();
      int s;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < BALLS; i++) begin
         s = int'(speed[2*i +: 2]);
         if (m_div[i] == 0) exp_q.push_back(i);
         m_div[i] = (m_div[i] >= s) ? 0 : m_div[i] + 1;
      end
      m_active = 1'b1;
      elapsed  = 0;
      stalls   = 0;
   endtask

   // One clock: drive inputs, advance the model, then observe #1 after the edge.
   task automatic step(input logic t, input logic p, input logic r);
      logic       pre_valid;
      logic [1:0] pre_ball;
      frame_tick = t;
      pause      = p;
      upd_ready  = r;
      pre_valid  = upd_valid;
      pre_ball   = upd_ball;
      if (m_active) begin
         elapsed++;
         if (pre_valid && !r) stalls++;
         if (t) m_overrun = 1'b1;
      end else if (!m_run) begin
         if (t) begin
            m_startup--;
            if (m_startup == 0) m_run = 1'b1;
         end
      end else if (t && !p) begin
         start_frame();
      end
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      if (pre_valid && r) begin
         got_q.push_back(int'(pre_ball));
         grant_cnt[pre_ball]++;
      end
      if (pre_valid && !r) begin
         check("valid_hold", 32'(upd_valid), 32'd1);
         check("ball_hold", 32'(upd_ball), 32'(pre_ball));
      end
      if (frame_done) begin
         check("done_expected", 32'(m_active), 32'd1);
         check("busy_at_done", 32'(busy), 32'd0);
         check("frame_len", 32'(elapsed), 32'(int'(BALLS) + exp_q.size() + stalls));
         check("grant_count", 32'(got_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check("grant_order", 32'(got_q[i]), 32'(exp_q[i]));
         m_active = 1'b0;
      end
      check("busy", 32'(busy), 32'(m_active));
      check("game_run", 32'(game_run), 32'(m_run));
      check("overrun", 32'(overrun), 32'(m_overrun));
      if (!m_active) check("valid_idle", 32'(upd_valid), 32'd0);
   endtask

   // Tick once, then run until the model's frame ends.
   // mode 0: ready high; mode 1: random ready and stray ticks;
   // mode 2: withhold ready 5 cycles on hold_ball, optional tick mid-hold.
   task automatic run_frame(input logic p, input int mode, input logic [1:0] hold_ball, input logic ovr);
      int   hold  = 0;
      int   guard = 0;
      logic r;
      logic t;
      step(1'b1, p, 1'b1);
      while (m_active && guard < 300) begin
         t = 1'b0;
         r = 1'b1;
         case (mode)
            1: begin
               r = ($urandom_range(0, 2) != 0);
               t = ($urandom_range(0, 19) == 0);
            end
            2: begin
               if (upd_valid && upd_ball == hold_ball && hold < 5) begin
                  r = 1'b0;
                  hold++;
                  if (ovr && hold == 3) t = 1'b1;
               end
            end
            default: ;
         endcase
         step(t, p, r);
         guard++;
      end
      if (m_active) begin
         check("frame_timeout", 32'(guard), 32'd0);
         m_active = 1'b0;
      end
      if (mode == 2) check("hold_len", 32'(hold), 32'd5);
      step(1'b0, p, 1'b1);
      step(1'b0, p, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int g;
      n_checks   = 0;
      n_pass     = 0;
      clk        = 1'b0;
      reset      = 1'b1;
      frame_tick = 1'b0;
      pause      = 1'b0;
      speed      = 8'hE4;
      upd_ready  = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_upd_ball", 32'(upd_ball), 32'd0);
      check("rst_game_run", 32'(game_run), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b1);

      // Startup countdown; the middle tick arrives with pause high.
      run_frame(1'b0, 0, 2'd0, 1'b0);
      run_frame(1'b1, 0, 2'd0, 1'b0);
      run_frame(1'b0, 0, 2'd0, 1'b0);

      // Eight running frames with speeds {3,2,1,0}.
      for (int i = 0; i < BALLS; i++) grant_cnt[i] = 0;
      repeat (8) run_frame(1'b0, 0, 2'd0, 1'b0);
      check("cnt_ball0", 32'(grant_cnt[0]), 32'd8);
      check("cnt_ball1", 32'(grant_cnt[1]), 32'd4);
      check("cnt_ball2", 32'(grant_cnt[2]), 32'd3);
      check("cnt_ball3", 32'(grant_cnt[3]), 32'd2);

      // Ready withheld on ball 1.
      run_frame(1'b0, 2, 2'd1, 1'b0);

      // Paused ticks are ignored, then scheduling resumes.
      repeat (3) run_frame(1'b1, 0, 2'd0, 1'b0);
      repeat (2) run_frame(1'b0, 0, 2'd0, 1'b0);

      // All balls due, then a tick lands while ball 2 waits for ready.
      speed = 8'h00;
      repeat (2) run_frame(1'b0, 0, 2'd0, 1'b0);
      run_frame(1'b0, 2, 2'd2, 1'b1);
      check("overrun_set", 32'(overrun), 32'd1);

      // Random speeds, ready, pause and stray ticks.
      repeat (150) begin
         speed = 8'($urandom);
         run_frame(logic'($urandom_range(0, 4) == 0), 1, 2'd0, 1'b0);
      end

      // Reset while a request is outstanding.
      speed = 8'h00;
      run_frame(1'b0, 0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      g = 0;
      while (!upd_valid && g < 10) begin
         step(1'b0, 1'b0, 1'b0);
         g++;
      end
      check("issue_reached", 32'(upd_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_upd_valid", 32'(upd_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_game_run", 32'(game_run), 32'd0);
      check("arst_overrun", 32'(overrun), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      speed = 8'hE4;
      step(1'b0, 1'b0, 1'b1);
      repeat (STARTUP) run_frame(1'b0, 0, 2'd0, 1'b0);
      repeat (2) run_frame(1'b0, 0, 2'd0, 1'b0);
      check("post_rst_cnt0", 32'(grant_cnt[0]), 32'd2);
      check("post_rst_cnt3", 32'(grant_cnt[3]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ball_update_scheduler.md
Name: ball_update_scheduler

Overview:
- Frame-level sequencer for the bouncing-ball datapath.
- Owns the startup countdown and the run/pause state.
- On each frame tick, walks balls 0..BALLS-1 and grants the shared ball-update/collision datapath to one ball at a time via a valid/ready handshake. Each ball is scheduled at its own speed divisor.
- Sits between the frame-tick generator and the single shared ball-mover, replacing per-ball free-running movers.

Parameters:
- BALLS, 4, number of balls scheduled (1..4).
- STARTUP_FRAMES, 255, frames counted down before the game runs (1..255).

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  single-cycle pulse, once per frame.
- pause  in  1  level; 1 = freeze scheduling.
- speed  in  2*BALLS  per-ball speed code, ball i at [2i+1:2i]; ball moves every (code+1) frames.
- upd_ready  in  1  shared datapath accepts the current request.
- upd_valid  out  1  request to update ball upd_ball.
- upd_ball  out  2  index of the ball being updated.
- game_run  out  1  startup countdown finished.
- busy  out  1  a frame scan is in progress (state != IDLE/STARTUP).
- frame_done  out  1  one-cycle pulse when a frame scan completes.
- overrun  out  1  sticky: a frame_tick arrived while busy.

Behaviour:
- Reset values: upd_valid=0, upd_ball=0, game_run=0, busy=0, frame_done=0, overrun=0, startup_cnt=STARTUP_FRAMES, all per-ball div_cnt=0, state=STARTUP. Reset mid-scan aborts immediately; no request is completed.
- States: STARTUP, IDLE, SCAN, ISSUE.
- STARTUP:
  - Each frame_tick decrements startup_cnt.
  - When startup_cnt reaches 0, the next state is IDLE and game_run=1 from the following cycle.
  - The tick that reaches 0 does not start a scan.
  - pause does not affect the countdown.
- IDLE:
  - frame_tick with pause=0 -> SCAN, idx=0, busy=1 on the next cycle.
  - frame_tick with pause=1 is ignored: counters frozen, no frame_done.
- SCAN (one cycle per ball):
  - due = (div_cnt[idx]==0).
  - div_cnt[idx] <= (div_cnt[idx] >= speed[idx]) ? 0 : div_cnt[idx]+1.
  - Using >= means a speed reduced below the current count wraps to 0.
  - If due -> ISSUE, with upd_valid=1 and upd_ball=idx registered, visible the next cycle.
  - If not due and idx==BALLS-1 -> IDLE. If not due otherwise -> idx+1, stay in SCAN.
- ISSUE:
  - upd_valid and upd_ball are held stable until upd_valid&&upd_ready.
  - In the handshake cycle, upd_valid deasserts the next cycle.
  - After the handshake: if idx==BALLS-1 -> IDLE, else idx+1 -> SCAN.
  - upd_ready while upd_valid=0 is ignored.
- Latency: tick at cycle t -> ball 0 SCAN at t+1 -> upd_valid at t+2 if due. Back-to-back due balls with ready tied high: one grant every 2 cycles.
- frame_done: one-cycle pulse in the cycle after the transition into IDLE from SCAN/ISSUE; busy=0 in that same cycle.
- overrun:
  - frame_tick while state is SCAN or ISSUE sets overrun=1 (sticky until reset). The tick is dropped; the scan continues unaffected.
  - A tick coinciding with the final handshake/transition into IDLE also counts as overrun and is dropped.
- pause asserted mid-scan does not abort the scan; it only gates the start of the next one.
- BALLS<4: upd_ball never exceeds BALLS-1; unused speed bits are ignored.
- Arithmetic: div_cnt is 2 bits, startup_cnt is 8 bits, with no wrap past 0.

Test Plan:
- STARTUP_FRAMES=3, 3 ticks -> game_run=0 after ticks 1-2, game_run=1 one cycle after tick 3, no upd_valid; tick 4 -> grants for balls 0,1,2,3 in order.
- speed={3,2,1,0} (ball3..ball0), ready=1, 8 running frames -> grant counts ball0=8, ball1=4, ball2=3 (frames 1,4,7), ball3=2 (frames 1,5).
- Ready withheld 5 cycles on ball 1 -> upd_valid=1 and upd_ball=1 held stable all 5 cycles, single grant, ball 2 SCAN follows the handshake.
- pause=1 across 3 ticks -> no upd_valid, no frame_done, div_cnt unchanged; pause=0 -> schedule resumes exactly where it stopped.
- Tick issued while ball 2 awaits ready -> overrun=1, scan completes normally, frame_done pulses once, overrun stays 1 until reset.
- Reset asserted during ISSUE -> upd_valid=0 and state=STARTUP immediately (async), startup_cnt=STARTUP_FRAMES, overrun=0.
